uart_tx: RTL and testbench

UART transmitter: serialises one byte per request into an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on a single line, one bit per `c_bittimerlim` clock cycles. It is the transmit counterpart of the UART receiver and sits between the on-chip byte source and the TX pad. The interface is a request/done-tick pair.

---
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with request/done-tick handshake
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din_i,
  input  logic       tx_start_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_tick_o
);

  localparam int c_bittimerlim = c_clkfreq / c_baudrate;

  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int              c_tw    = clog2_f(c_bittimerlim);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(c_bittimerlim - 1);
  // The last stop-bit cycle is spent in S_IDLE (done tick), so S_STOP ends one cycle early.
  localparam logic [c_tw-1:0] c_slast = c_tw'(c_bittimerlim - 2);
  localparam logic [c_tw-1:0] c_one   = c_tw'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t          state_q, state_d;
  logic [c_tw-1:0] timer_q, timer_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [2:0]      bit_nxt;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign bit_nxt = bitcnt_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + c_one;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        if (tx_start_i) begin
          shreg_d = din_i;
`ifdef UART_TX_PARITY_EN
          parity_d = ^din_i;
`endif
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (timer_q == c_tlast) begin
          timer_d = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (timer_q == c_tlast) begin
          timer_d = '0;
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bitcnt_d = bit_nxt;
            tx_d     = shreg_q[bit_nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_q == c_tlast) begin
          timer_d = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (timer_q == c_slast) begin
          timer_d = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        bitcnt_d = '0;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign tx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (10 cycles/bit instance plus default-rate instance)
module tb_uart_tx;

  localparam int LIM = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int DONE_K = 109;
`else
  localparam int NB = 10;
  localparam int DONE_K = 99;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       start;
  logic       tx, busy, done;
  logic [7:0] din_b;
  logic       start_b;
  logic       tx_b, busy_b, done_b;

  always #5 clk = ~clk;

  uart_tx #(.c_clkfreq(10), .c_baudrate(1)) dut (
    .clk(clk), .rst(rst), .din_i(din), .tx_start_i(start),
    .tx_o(tx), .busy_o(busy), .tx_done_tick_o(done)
  );

  uart_tx dut_b (
    .clk(clk), .rst(rst), .din_i(din_b), .tx_start_i(start_b),
    .tx_o(tx_b), .busy_o(busy_b), .tx_done_tick_o(done_b)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of NB bits, each LIM cycles; k counts cycles since acceptance.
  bit         m_act = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
    end else if ((!m_act || m_k >= NB*LIM-1) && start) begin
      m_act  <= 1'b1;
      m_k    <= 0;
      m_byte <= din;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 >= NB*LIM) m_act <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tx",   tx,   m_act ? frame_bit(m_byte, m_k / LIM) : 1'b1);
      chk("model_busy", busy, m_act && (m_k < NB*LIM-1));
      chk("model_done", done, m_act && (m_k == NB*LIM-1));
    end
  end

  task automatic send_and_watch(input logic [7:0] b, input int inj_k,
                                output logic [7:0] got, output logic sbit, output logic b9,
                                output int dcnt, output int dpos, output logic busy_inj);
    din = b;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    got = 8'h00; sbit = 1'bx; b9 = 1'bx; dcnt = 0; dpos = -1; busy_inj = 1'b0;
    for (int k = 0; k < NB*LIM + 3; k++) begin
      @(negedge clk);
      if (k == LIM/2) sbit = tx;
      if (k >= LIM && k < 9*LIM && (k % LIM) == LIM/2) got[k/LIM-1] = tx;
      if (k == 9*LIM + LIM/2) b9 = tx;
      if (done) begin dcnt++; dpos = k; end
      if (k == inj_k) begin din = 8'h3C; start = 1'b1; end
      if (k == inj_k + 1) busy_inj = busy;
      if (k == inj_k + 2) start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got;
    logic       sbit, b9, bi;
    int         dcnt, dpos, d1, d2, run, nw;
    logic       prev;
    logic [7:0] got2;
    logic       tx99, tx100;

    rst = 1'b1; din = 8'h00; start = 1'b0; din_b = 8'h00; start_b = 1'b0;
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // A5: bit centres 0,1,0,1,0,0,1,0,1,(stop)1
    @(posedge clk); #2;
    send_and_watch(8'hA5, -10, got, sbit, b9, dcnt, dpos, bi);
    chk("a5_start", sbit, 1'b0);
    chk("a5_data", got, 8'hA5);
    chk("a5_bit9", b9, 1'b1);
    chk("a5_done_cnt", dcnt, 1);
    chk("a5_done_pos", dpos, DONE_K);

    // Back-to-back: start held, 00 then FF
    @(posedge clk); #2;
    din = 8'h00; start = 1'b1;
    @(posedge clk);
    #2 din = 8'hFF;
    d1 = -1; d2 = -1; got2 = 8'h00; tx99 = 1'bx; tx100 = 1'bx;
    for (int k = 0; k < 2*NB*LIM + 5; k++) begin
      @(negedge clk);
      if (done) begin if (d1 < 0) d1 = k; else d2 = k; end
      if (k == NB*LIM-1) tx99 = tx;
      if (k == NB*LIM) tx100 = tx;
      if (k >= NB*LIM + LIM && k < NB*LIM + 9*LIM && (k % LIM) == LIM/2)
        got2[(k - NB*LIM)/LIM - 1] = tx;
      if (k == NB*LIM + 20) start = 1'b0;
    end
    chk("b2b_done1", d1, DONE_K);
    chk("b2b_gap", d2 - d1, NB*LIM);
    chk("b2b_stop_tail", tx99, 1'b1);
    chk("b2b_next_start", tx100, 1'b0);
    chk("b2b_second_byte", got2, 8'hFF);

    // 81 with a mid-frame request carrying 3C
    @(posedge clk); #2;
    send_and_watch(8'h81, 30, got, sbit, b9, dcnt, dpos, bi);
    chk("ign_data", got, 8'h81);
    chk("ign_busy", bi, 1'b1);
    chk("ign_done_cnt", dcnt, 1);

    // Reset during data bit 3
    @(posedge clk); #2;
    din = 8'hC3; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (46) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    dcnt = 0;
    repeat (3) begin @(negedge clk); if (done) dcnt++; end
    chk("rst_mid_nodone", dcnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    send_and_watch(8'h5A, -10, got, sbit, b9, dcnt, dpos, bi);
    chk("post_rst_data", got, 8'h5A);
    chk("post_rst_done", dpos, DONE_K);

    // 07: with parity this bit is the parity bit (1), otherwise the stop bit
    @(posedge clk); #2;
    send_and_watch(8'h07, -10, got, sbit, b9, dcnt, dpos, bi);
    chk("p07_data", got, 8'h07);
    chk("p07_bit9", b9, 1'b1);
    chk("p07_done_pos", dpos, DONE_K);

    // Default rate: 55 toggles every bit, so each run length is one bit width
    @(posedge clk); #2;
    din_b = 8'h55; start_b = 1'b1;
    @(posedge clk);
    #2 start_b = 1'b0;
    prev = 1'b0; run = 0; nw = 0; dcnt = 0;
    for (int k = 0; k < 12000; k++) begin
      @(negedge clk);
      if (tx_b !== prev) begin
        chk("width_868", run, 868);
        nw++;
        run = 0;
        prev = tx_b;
      end
      run++;
      if (done_b) begin dcnt = 1; break; end
    end
    chk("width_done_seen", dcnt, 1);
    chk("width_runs", nw, NB-1);
    chk("width_stop", run, 868);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
